clk_div_monitor: RTL

- Sits directly downstream of the even-ratio clock divider, in the clk_in domain.
- Samples the divided clock as data and produces single-cycle rise/fall strobes for fast-domain logic.
- Counts slow-clock rising edges and checks every half-period against the expected DIVISOR/2.
- Runs a lock/stall state machine so control logic knows when the slow clock is trustworthy.

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/clk_div_monitor_edge_detect.sv | 51 +++++
 rtl/clk_div_monitor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state type and ratio helpers for the clock divider and its monitor.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        STALL   = 2'd3
    } mon_state_e;

    // Expected clk_in cycles per divided-clock phase.
    function automatic int half_period(input int divisor);
        return divisor / 2;
    endfunction

    function automatic bit divisor_ok(input int divisor);
        return (divisor >= 2) && ((divisor % 2) == 0);
    endfunction

endpackage

// File: rtl/clk_div_monitor_edge_detect.sv
// rtl/clk_div_monitor_edge_detect.sv - samples the divided clock and produces edge detects and registered strobes.
// CLK_DIV_MONITOR_SYNC_EN inserts a 2-flop synchronizer ahead of the sampling flop.
module clk_div_monitor_edge_detect (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clk_div,
    output logic edge_det,
    output logic rise_det,
    output logic rise_stb,
    output logic fall_stb
);

    logic sample;
    logic d_q;
    logic primed;

`ifdef CLK_DIV_MONITOR_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], clk_div};
        end
    end

    assign sample = sync_q[1];
`else
    assign sample = clk_div;
`endif

    // d_q resets low, so the first post-reset cycle is masked to avoid a false rise.
    assign edge_det = primed && (sample != d_q);
    assign rise_det = edge_det && sample;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            d_q      <= 1'b0;
            primed   <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            d_q      <= sample;
            primed   <= 1'b1;
            rise_stb <= rise_det;
            fall_stb <= edge_det && !sample;
        end
    end

endmodule

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - edge strobes, tick counter, half-period check and lock/stall FSM for a divided clock.
// Optional CLK_DIV_MONITOR_SYNC_EN synchronizes clk_div before sampling (see edge_detect).
module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int DIVISOR    = 4,
    parameter int CNT_W      = 16,
    parameter int LOCK_EDGES = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             clk_div,
    input  logic             cnt_clr,
    input  logic             err_clr,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] tick_count,
    output logic             period_err,
    output logic             locked,
    output logic             stalled
);

    localparam int HP_W   = $clog2(TIMEOUT + 1);
    localparam int GOOD_W = $clog2(LOCK_EDGES + 1);

    localparam logic [HP_W-1:0]   HP_MAX    = HP_W'(TIMEOUT);
    localparam logic [HP_W:0]     HP_EXPECT = (HP_W + 1)'(half_period(DIVISOR));
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_EDGES - 1);

    if (!divisor_ok(DIVISOR)) begin : g_chk_divisor
        $fatal(1, "clk_div_monitor: DIVISOR must be even and >= 2");
    end
    if (LOCK_EDGES < 1) begin : g_chk_lock
        $fatal(1, "clk_div_monitor: LOCK_EDGES must be >= 1");
    end
    if (TIMEOUT <= half_period(DIVISOR)) begin : g_chk_timeout
        $fatal(1, "clk_div_monitor: TIMEOUT must exceed DIVISOR/2");
    end

    logic edge_det;
    logic rise_det;

    clk_div_monitor_edge_detect u_edge (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .clk_div  (clk_div),
        .edge_det (edge_det),
        .rise_det (rise_det),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    mon_state_e        state;
    mon_state_e        state_nxt;
    logic [HP_W-1:0]   hp_cnt;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_nxt;
    logic              period_ok;
    logic              timeout;
    logic              err_set;

    // hp_cnt holds cycles since the last edge, so the phase just ended is hp_cnt+1 long.
    assign period_ok = (({1'b0, hp_cnt} + (HP_W + 1)'(1)) == HP_EXPECT);
    assign timeout   = (hp_cnt == HP_MAX);

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (edge_det) begin
                    state_nxt = ACQUIRE;
                    good_nxt  = '0;
                end else if (timeout) begin
                    state_nxt = STALL;
                end
            end
            ACQUIRE: begin
                if (edge_det) begin
                    if (period_ok) begin
                        if (good_cnt == GOOD_LAST) begin
                            state_nxt = LOCKED;
                            good_nxt  = '0;
                        end else begin
                            good_nxt = good_cnt + GOOD_W'(1);
                        end
                    end else begin
                        good_nxt = '0;
                        err_set  = 1'b1;
                    end
                end else if (timeout) begin
                    state_nxt = STALL;
                end
            end
            LOCKED: begin
                if (edge_det) begin
                    if (!period_ok) begin
                        state_nxt = ACQUIRE;
                        good_nxt  = '0;
                        err_set   = 1'b1;
                    end
                end else if (timeout) begin
                    state_nxt = STALL;
                end
            end
            STALL: begin
                if (edge_det) begin
                    state_nxt = ACQUIRE;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                good_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            good_cnt <= '0;
            locked   <= 1'b0;
            stalled  <= 1'b0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            locked   <= (state_nxt == LOCKED);
            stalled  <= (state_nxt == STALL);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hp_cnt <= '0;
        end else if (edge_det) begin
            hp_cnt <= '0;
        end else if (!timeout) begin
            hp_cnt <= hp_cnt + HP_W'(1);
        end
    end

    // A clear coincident with a rise counts that rise.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick_count <= '0;
        end else if (cnt_clr) begin
            tick_count <= CNT_W'(rise_det);
        end else if (rise_det) begin
            tick_count <= tick_count + CNT_W'(1);
        end
    end

    // A new mismatch outranks err_clr in the same cycle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            period_err <= 1'b0;
        end else begin
            period_err <= (period_err && !err_clr) || err_set;
        end
    end

endmodule
